// File: rtl/counter_pkg.sv
// Shared definitions for the counter family (up counter, down timer).
// Holds the down-timer state encoding and a helper that sizes prescaler
// phase counters.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } down_timer_state_t;

    // Prescaler phase width: $clog2(PRESCALE), never narrower than one bit,
    // so PRESCALE=1 still gets a legal (constant-zero) phase register.
    function automatic int prescale_width(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Tick prescaler: emits a single-cycle tick every PRESCALE enabled cycles.
// The tick is combinational on the cycle the phase reaches PRESCALE-1; the
// phase then wraps to 0. en=0 freezes the phase, clr forces it to 0.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign tick = en && (phase == LAST);

    // Phase counter: cleared by reset or clr, advances only while enabled.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= tick ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaled decrement and a one-cycle
// terminal-count pulse.
// Optional feature: define DOWN_TIMER_AUTO_RELOAD_EN for periodic mode, where
// the terminal tick reloads the last loaded value and the timer keeps running.
module down_timer
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             en,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc_pulse
);

    down_timer_state_t state;
    logic              tick;
    logic              presc_clr;
    logic              presc_en;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0]  reload;
`endif

    // The prescaler only runs in RUN; leaving RUN or a stop restarts its phase.
    assign presc_clr  = (state != RUN) || stop;
    assign presc_en   = en && (state == RUN);
    assign load_ready = (state == IDLE);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    // Timer FSM with registered count, busy and terminal-count pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            busy     <= 1'b0;
            tc_pulse <= 1'b0;
        end else begin
            tc_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        count <= load_value;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                        reload <= load_value;
`endif
                        if (load_value != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            // A zero load terminates immediately.
                            state    <= DONE;
                            tc_pulse <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        // Abort keeps the current count visible; no pulse even
                        // if this was the terminal tick.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        if (count == WIDTH'(1)) begin
                            tc_pulse <= 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                            count <= reload;
`else
                            count <= '0;
                            state <= DONE;
                            busy  <= 1'b0;
`endif
                        end else if (count != '0) begin
                            count <= count - WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
